sobel_row_loader: RTL and testbench

//  Input-side feeder for the Sobel accelerator cores. Fetches image rows from memory over a

---
 rtl/sobel_row_loader.sv | 181 ++++++++++++++++++
 tb/tb_sobel_row_loader.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_row_loader.sv
// Sliding 3-row window feeder for the Sobel cores: fetches rows over a single-outstanding read port.
// Optional background row prefetch into a shadow register is enabled by defining SOBEL_ROW_PREFETCH_EN.
module sobel_row_loader #(
  parameter int NUM_ACC = 4,
  parameter int IDATA_W = (NUM_ACC + 2) * 8,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ctrl_start,
  input  logic [ADDR_W-1:0]  ctrl_base_addr,
  input  logic [15:0]        ctrl_stride,
  input  logic [15:0]        ctrl_num_rows,
  output logic               ctrl_busy,
  output logic               ctrl_done,
  output logic               mem_rd_req,
  output logic [ADDR_W-1:0]  mem_rd_addr,
  input  logic               mem_rd_valid,
  input  logic [IDATA_W-1:0] mem_rd_data,
  output logic [IDATA_W-1:0] srow2sacc_row1_data,
  output logic [IDATA_W-1:0] srow2sacc_row2_data,
  output logic [IDATA_W-1:0] srow2sacc_row3_data,
  output logic               srow_valid,
  input  logic               swt_advance,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_READY = 3'd2,
    S_FETCH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state;
  logic [15:0] stride_q;
  logic [15:0] num_rows_q;
  logic [15:0] rows_fetched;
  logic        capture;
  logic        more_rows;

  // Read handshake: mem_rd_req and mem_rd_addr hold until mem_rd_valid; a beat is
  // taken only when both are high, and mem_rd_valid with mem_rd_req low is ignored.
  assign capture   = mem_rd_req & mem_rd_valid;
  assign more_rows = (rows_fetched != num_rows_q);
  assign dbg_state = state;

`ifdef SOBEL_ROW_PREFETCH_EN
  logic [IDATA_W-1:0] shadow;
  logic               shadow_full;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= S_IDLE;
      stride_q            <= '0;
      num_rows_q          <= '0;
      rows_fetched        <= '0;
      ctrl_busy           <= 1'b0;
      ctrl_done           <= 1'b0;
      mem_rd_req          <= 1'b0;
      mem_rd_addr         <= '0;
      srow2sacc_row1_data <= '0;
      srow2sacc_row2_data <= '0;
      srow2sacc_row3_data <= '0;
      srow_valid          <= 1'b0;
`ifdef SOBEL_ROW_PREFETCH_EN
      shadow              <= '0;
      shadow_full         <= 1'b0;
`endif
    end else begin
      ctrl_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ctrl_start) begin
            stride_q     <= ctrl_stride;
            num_rows_q   <= ctrl_num_rows;
            rows_fetched <= '0;
            ctrl_busy    <= 1'b1;
            mem_rd_addr  <= ctrl_base_addr;
            if (ctrl_num_rows < 16'd3) begin
              state <= S_DONE;
            end else begin
              mem_rd_req <= 1'b1;
              state      <= S_FILL;
            end
          end
        end

        S_FILL: begin
          if (capture) begin
            mem_rd_req   <= 1'b0;
            mem_rd_addr  <= mem_rd_addr + ADDR_W'(stride_q);
            rows_fetched <= rows_fetched + 16'd1;
            case (rows_fetched[1:0])
              2'd0:    srow2sacc_row1_data <= mem_rd_data;
              2'd1:    srow2sacc_row2_data <= mem_rd_data;
              default: begin
                srow2sacc_row3_data <= mem_rd_data;
                srow_valid          <= 1'b1;
                state               <= S_READY;
              end
            endcase
          end else if (!mem_rd_req) begin
            mem_rd_req <= 1'b1;
          end
        end

        S_READY: begin
`ifdef SOBEL_ROW_PREFETCH_EN
          if (swt_advance) begin
            if (!more_rows && !shadow_full) begin
              srow_valid <= 1'b0;
              state      <= S_DONE;
            end else begin
              srow2sacc_row1_data <= srow2sacc_row2_data;
              srow2sacc_row2_data <= srow2sacc_row3_data;
              if (shadow_full) begin
                srow2sacc_row3_data <= shadow;
                shadow_full         <= 1'b0;
              end else if (capture) begin
                // Row lands on the advance cycle: bypass the shadow entirely.
                srow2sacc_row3_data <= mem_rd_data;
                mem_rd_req          <= 1'b0;
                mem_rd_addr         <= mem_rd_addr + ADDR_W'(stride_q);
                rows_fetched        <= rows_fetched + 16'd1;
              end else begin
                srow_valid <= 1'b0;
                mem_rd_req <= 1'b1;
                state      <= S_FETCH;
              end
            end
          end else if (capture) begin
            shadow       <= mem_rd_data;
            shadow_full  <= 1'b1;
            mem_rd_req   <= 1'b0;
            mem_rd_addr  <= mem_rd_addr + ADDR_W'(stride_q);
            rows_fetched <= rows_fetched + 16'd1;
          end else if (!mem_rd_req && !shadow_full && more_rows) begin
            mem_rd_req <= 1'b1;
          end
`else
          if (swt_advance) begin
            srow_valid <= 1'b0;
            if (!more_rows) begin
              state <= S_DONE;
            end else begin
              srow2sacc_row1_data <= srow2sacc_row2_data;
              srow2sacc_row2_data <= srow2sacc_row3_data;
              mem_rd_req          <= 1'b1;
              state               <= S_FETCH;
            end
          end
`endif
        end

        S_FETCH: begin
          if (capture) begin
            srow2sacc_row3_data <= mem_rd_data;
            srow_valid          <= 1'b1;
            mem_rd_req          <= 1'b0;
            mem_rd_addr         <= mem_rd_addr + ADDR_W'(stride_q);
            rows_fetched        <= rows_fetched + 16'd1;
            state               <= S_READY;
          end
        end

        S_DONE: begin
          // Row registers deliberately keep the last window.
          ctrl_done <= 1'b1;
          ctrl_busy <= 1'b0;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_row_loader.sv
// Self-checking bench for sobel_row_loader: memory responder, address/window scoreboard, scenario tasks.
module tb_sobel_row_loader;

  localparam int NUM_ACC = 4;
  localparam int IDATA_W = (NUM_ACC + 2) * 8;
  localparam int ADDR_W  = 32;

  logic               clk = 1'b0;
  logic               reset;
  logic               ctrl_start;
  logic [ADDR_W-1:0]  ctrl_base_addr;
  logic [15:0]        ctrl_stride;
  logic [15:0]        ctrl_num_rows;
  logic               ctrl_busy;
  logic               ctrl_done;
  logic               mem_rd_req;
  logic [ADDR_W-1:0]  mem_rd_addr;
  logic               mem_rd_valid;
  logic [IDATA_W-1:0] mem_rd_data;
  logic [IDATA_W-1:0] row1, row2, row3;
  logic               srow_valid;
  logic               swt_advance;
  logic [2:0]         dbg_state;

  int checks = 0;
  int errors = 0;
  int mem_lat = 1;

  logic [ADDR_W-1:0]    addr_q[$];
  logic [3*IDATA_W-1:0] exp_q[$];

  sobel_row_loader #(.NUM_ACC(NUM_ACC), .IDATA_W(IDATA_W), .ADDR_W(ADDR_W)) dut (
    .clk                 (clk),
    .reset               (reset),
    .ctrl_start          (ctrl_start),
    .ctrl_base_addr      (ctrl_base_addr),
    .ctrl_stride         (ctrl_stride),
    .ctrl_num_rows       (ctrl_num_rows),
    .ctrl_busy           (ctrl_busy),
    .ctrl_done           (ctrl_done),
    .mem_rd_req          (mem_rd_req),
    .mem_rd_addr         (mem_rd_addr),
    .mem_rd_valid        (mem_rd_valid),
    .mem_rd_data         (mem_rd_data),
    .srow2sacc_row1_data (row1),
    .srow2sacc_row2_data (row2),
    .srow2sacc_row3_data (row3),
    .srow_valid          (srow_valid),
    .swt_advance         (swt_advance),
    .dbg_state           (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [IDATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {a[15:0] ^ 16'h3C3C, a ^ 32'hA5A5_5A5A};
  endfunction

  // memory model: valid after mem_lat cycles of req, held one cycle
  initial begin : responder
    int cnt;
    cnt = 0;
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        mem_rd_valid = 1'b0;
        cnt = 0;
      end else if (mem_rd_valid) begin
        mem_rd_valid = 1'b0;
        cnt = 0;
      end else if (mem_rd_req) begin
        if (cnt >= mem_lat) begin
          mem_rd_valid = 1'b1;
          mem_rd_data  = mem_word(mem_rd_addr);
        end else begin
          cnt++;
        end
      end
    end
  end

  task automatic run_strip(input logic [ADDR_W-1:0] base, input logic [15:0] stride,
                           input logic [15:0] nrows, input int adv_wait,
                           output int n_win, output int n_reads, output int max_bub,
                           output int min_bub);
    logic [ADDR_W-1:0]    a, a0, a1, a2;
    logic [3*IDATA_W-1:0] cur, last, exp;
    bit need, seen_win, finished;
    int hold, bub;
    addr_q.delete();
    exp_q.delete();
    if (nrows >= 16'd3) begin
      for (int k = 0; k < int'(nrows); k++) begin
        a = base + ADDR_W'(k) * ADDR_W'(stride);
        addr_q.push_back(a);
      end
      for (int j = 0; j < int'(nrows) - 2; j++) begin
        a0 = base + ADDR_W'(j) * ADDR_W'(stride);
        a1 = base + ADDR_W'(j + 1) * ADDR_W'(stride);
        a2 = base + ADDR_W'(j + 2) * ADDR_W'(stride);
        exp_q.push_back({mem_word(a0), mem_word(a1), mem_word(a2)});
      end
    end
    @(negedge clk);
    ctrl_base_addr = base;
    ctrl_stride    = stride;
    ctrl_num_rows  = nrows;
    ctrl_start     = 1'b1;
    @(posedge clk);
    #2;
    ctrl_start = 1'b0;
    need = 1; seen_win = 0; finished = 0; hold = 0; bub = 0; last = '0;
    n_win = 0; n_reads = 0; max_bub = 0; min_bub = 1000;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      if (mem_rd_req && mem_rd_valid) begin
        n_reads++;
        checks++;
        if (addr_q.size() == 0) begin
          errors++;
          $display("FAIL rd_addr: unexpected read at %h, no read required", mem_rd_addr);
        end else begin
          a = addr_q.pop_front();
          if (mem_rd_addr !== a) begin
            errors++;
            $display("FAIL rd_addr: got %h, expected %h", mem_rd_addr, a);
          end
        end
      end
      if (ctrl_done) begin
        finished = 1;
        checks++;
        if (ctrl_busy !== 1'b0) begin
          errors++;
          $display("FAIL done_busy: busy=%b with done, expected 0", ctrl_busy);
        end
      end else if (srow_valid) begin
        cur = {row1, row2, row3};
        if (need) begin
          n_win++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL window: unexpected window %h", cur);
          end else begin
            exp = exp_q.pop_front();
            if (cur !== exp) begin
              errors++;
              $display("FAIL window: got %h, expected %h", cur, exp);
            end
          end
          if (seen_win) begin
            if (bub > max_bub) max_bub = bub;
            if (bub < min_bub) min_bub = bub;
          end
          seen_win = 1; need = 0; hold = 0; bub = 0; last = cur;
        end else begin
          hold++;
          checks++;
          if (cur !== last) begin
            errors++;
            $display("FAIL window_stable: got %h, expected %h", cur, last);
          end
        end
        if (hold >= adv_wait) swt_advance = 1'b1;
      end else if (seen_win) begin
        bub++;
      end
      @(posedge clk);
      #2;
      if (swt_advance) begin
        swt_advance = 1'b0;
        need = 1;
      end
    end
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL strip_timeout: no done within 3000 cycles, expected done");
    end
    checks++;
    if (addr_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d reads %0d windows pending, expected 0 0",
               addr_q.size(), exp_q.size());
    end
    checks++;
    if (ctrl_done !== 1'b0 || ctrl_busy !== 1'b0) begin
      errors++;
      $display("FAIL done_width: done=%b busy=%b after pulse, expected 0 0", ctrl_done, ctrl_busy);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (mem_rd_req !== 1'b0 || ctrl_busy !== 1'b0 || ctrl_done !== 1'b0 || srow_valid !== 1'b0 ||
        row1 !== '0 || row2 !== '0 || row3 !== '0 || mem_rd_addr !== '0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: req=%b busy=%b done=%b valid=%b addr=%h st=%0d, expected all 0",
               mem_rd_req, ctrl_busy, ctrl_done, srow_valid, mem_rd_addr, dbg_state);
    end
    @(negedge clk);
    reset = 1'b0;
    mem_lat = 3;
    ctrl_base_addr = 32'h0000_2000;
    ctrl_stride    = 16'h0040;
    ctrl_num_rows  = 16'd5;
    ctrl_start     = 1'b1;
    @(posedge clk);
    #2;
    ctrl_start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    checks++;
    if (dbg_state !== 3'd1 || row1 !== mem_word(32'h0000_2000) || ctrl_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_fill: st=%0d row1=%h busy=%b, expected 1 %h 1",
               dbg_state, row1, ctrl_busy, mem_word(32'h0000_2000));
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (mem_rd_req !== 1'b0 || ctrl_busy !== 1'b0 || srow_valid !== 1'b0 || row1 !== '0 ||
        row2 !== '0 || row3 !== '0 || mem_rd_addr !== '0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL async_reset: req=%b busy=%b valid=%b row1=%h addr=%h, expected all 0",
               mem_rd_req, ctrl_busy, srow_valid, row1, mem_rd_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2;
      checks++;
      if (ctrl_done !== 1'b0 || ctrl_busy !== 1'b0 || mem_rd_req !== 1'b0) begin
        errors++;
        $display("FAIL post_abort: done=%b busy=%b req=%b, expected 0 0 0",
                 ctrl_done, ctrl_busy, mem_rd_req);
      end
    end
  endtask

  task automatic test_basic;
    int nw, nr, mx, mn;
    mem_lat = 1;
    run_strip(32'h0000_1000, 16'h0200, 16'd5, 1, nw, nr, mx, mn);
    checks++;
    if (nw != 3 || nr != 5) begin
      errors++;
      $display("FAIL basic_counts: windows=%0d reads=%0d, expected 3 5", nw, nr);
    end
  endtask

  task automatic test_short_strip;
    @(negedge clk);
    ctrl_base_addr = 32'h0000_3000;
    ctrl_stride    = 16'h0010;
    ctrl_num_rows  = 16'd2;
    ctrl_start     = 1'b1;
    @(posedge clk);
    #2;
    ctrl_start = 1'b0;
    checks++;
    if (ctrl_busy !== 1'b1 || ctrl_done !== 1'b0 || mem_rd_req !== 1'b0) begin
      errors++;
      $display("FAIL short_c1: busy=%b done=%b req=%b, expected 1 0 0", ctrl_busy, ctrl_done, mem_rd_req);
    end
    @(posedge clk);
    #2;
    checks++;
    if (ctrl_done !== 1'b1 || ctrl_busy !== 1'b0 || mem_rd_req !== 1'b0 || srow_valid !== 1'b0) begin
      errors++;
      $display("FAIL short_c2: done=%b busy=%b req=%b valid=%b, expected 1 0 0 0",
               ctrl_done, ctrl_busy, mem_rd_req, srow_valid);
    end
    @(posedge clk);
    #2;
    checks++;
    if (ctrl_done !== 1'b0 || mem_rd_req !== 1'b0) begin
      errors++;
      $display("FAIL short_c3: done=%b req=%b, expected 0 0", ctrl_done, mem_rd_req);
    end
  endtask

  task automatic test_backpressure;
    int nw, nr, mx, mn;
    mem_lat = 1;
    run_strip(32'h0000_4000, 16'h0080, 16'd4, 20, nw, nr, mx, mn);
    checks++;
    if (nw != 2 || nr != 4) begin
      errors++;
      $display("FAIL backpressure_counts: windows=%0d reads=%0d, expected 2 4", nw, nr);
    end
  endtask

  task automatic test_wrap;
    int nw, nr, mx, mn;
    mem_lat = 1;
    run_strip(32'hFFFF_FF00, 16'h0100, 16'd3, 0, nw, nr, mx, mn);
    checks++;
    if (nw != 1 || nr != 3) begin
      errors++;
      $display("FAIL wrap_counts: windows=%0d reads=%0d, expected 1 3", nw, nr);
    end
  endtask

  task automatic test_prefetch;
    int nw, nr, mx, mn;
    mem_lat = 1;
    run_strip(32'h0000_8000, 16'h0030, 16'd6, 2, nw, nr, mx, mn);
    checks++;
    if (nw != 4 || nr != 6) begin
      errors++;
      $display("FAIL prefetch_counts: windows=%0d reads=%0d, expected 4 6", nw, nr);
    end
    checks++;
`ifdef SOBEL_ROW_PREFETCH_EN
    if (mx != 0) begin
      errors++;
      $display("FAIL zero_bubble: max gap %0d cycles, expected 0", mx);
    end
`else
    if (mn < 2) begin
      errors++;
      $display("FAIL fetch_bubble: min gap %0d cycles, expected >= 2", mn);
    end
`endif
  endtask

  task automatic test_random;
    int nw, nr, mx, mn;
    logic [ADDR_W-1:0] base;
    logic [15:0] stride, nrows;
    for (int t = 0; t < 4; t++) begin
      mem_lat = int'($urandom_range(0, 3));
      base    = $urandom();
      stride  = 16'($urandom_range(1, 16'hFFFF));
      nrows   = 16'($urandom_range(3, 8));
      run_strip(base, stride, nrows, int'($urandom_range(0, 5)), nw, nr, mx, mn);
      checks++;
      if (nw != int'(nrows) - 2 || nr != int'(nrows)) begin
        errors++;
        $display("FAIL random_counts: windows=%0d reads=%0d, expected %0d %0d",
                 nw, nr, int'(nrows) - 2, int'(nrows));
      end
    end
  endtask

  initial begin
    reset          = 1'b1;
    ctrl_start     = 1'b0;
    ctrl_base_addr = '0;
    ctrl_stride    = '0;
    ctrl_num_rows  = '0;
    swt_advance    = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    test_reset;
    test_basic;
    test_short_strip;
    test_backpressure;
    test_wrap;
    test_prefetch;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
